// File: rtl/conv_param_pkg.sv
// Shared types for the convolution-parameter generator: FSM states, lane-width
// helper and the packed result bundle seen by the address/add/result blocks.
package conv_param_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_MUL0,
        ST_MUL1,
        ST_MUL2,
        ST_MUL3,
        ST_FIN,
        ST_DONE,
        ST_ERR
    } conv_state_e;

    function automatic int s2p_log2(input int s2p);
        return $clog2(s2p);
    endfunction

    // Field widths of the result bundle for the default build of the generator.
    localparam int CP_TP_W   = 9;
    localparam int CP_KKC_W  = 16;
    localparam int CP_LANE_W = 3;
    localparam int CP_KNUM_W = 8;
    localparam int CP_PIX_W  = 18;
    localparam int CP_ROW_W  = 12;
    localparam int CP_ADDR_W = 16;

    typedef struct packed {
        logic                 param_valid;
        logic                 param_err;
        logic [CP_TP_W-1:0]   ofs;
        logic [CP_KKC_W-1:0]  kkc;
        logic [CP_KKC_W-1:0]  col_blk_last;
        logic [CP_LANE_W-1:0] col_lane_last;
        logic [CP_KNUM_W-1:0] kn_blk;
        logic [CP_LANE_W-1:0] kn_lane_last;
        logic [CP_PIX_W-1:0]  pix;
        logic [CP_PIX_W-1:0]  pix_blk;
        logic [CP_LANE_W-1:0] pix_rem;
        logic [CP_ROW_W-1:0]  row_step;
        logic [CP_ADDR_W-1:0] ska;
    } conv_param_t;

endpackage

// File: rtl/conv_param_div.sv
// Start/done iterative-subtract divider: yields floor(dividend/divisor)+1 and
// the number of enabled cycles it took.
module conv_param_div #(
    parameter int N_W = 9,
    parameter int D_W = 3
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           start,
    input  logic           en,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           done,
    output logic [N_W-1:0] quot_p1,
    output logic [N_W-1:0] cycles
);

    logic [N_W:0]   acc;
    logic [N_W:0]   acc_nxt;
    logic [N_W-1:0] cnt;

    assign acc_nxt = acc + (N_W+1)'(divisor);
    // Finishes on the step that would overshoot, so a quotient q takes q+1 cycles.
    assign done    = en && (acc_nxt > {1'b0, dividend});
    assign quot_p1 = cnt + N_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc    <= '0;
            cnt    <= '0;
            cycles <= '0;
        end else if (start) begin
            acc    <= '0;
            cnt    <= '0;
            cycles <= '0;
        end else if (en) begin
            cycles <= cycles + N_W'(1);
            if (!done) begin
                acc <= acc_nxt;
                cnt <= cnt + N_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_param_gen.sv
// Convolution-parameter generator: validates one layer config and derives the
// IMG2COL/GEMM counts sequentially. Padding input exists only with CONV_PARAM_PAD_EN.
module conv_param_gen
    import conv_param_pkg::*;
#(
    parameter int TENSOR_W  = 8,
    parameter int KERNEL_W  = 4,
    parameter int CHANNEL_W = 8,
    parameter int STRIDE_W  = 3,
    parameter int PAD_W     = 3,
    parameter int KNUM_W    = 8,
    parameter int S2P       = 8,
    parameter int ADDR_W    = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              clear,
    input  logic                              cfg_valid,
    output logic                              cfg_ready,
    input  logic [TENSOR_W-1:0]               tensor_size,
    input  logic [KERNEL_W-1:0]               kernel_size,
    input  logic [CHANNEL_W-1:0]              channels,
    input  logic [STRIDE_W-1:0]               stride,
`ifdef CONV_PARAM_PAD_EN
    input  logic [PAD_W-1:0]                  pad,
`endif
    input  logic [KNUM_W-1:0]                 kernel_nums,
    output logic                              param_valid,
    output logic                              param_err,
    output logic [TENSOR_W:0]                 ofs,
    output logic [2*KERNEL_W+CHANNEL_W-1:0]   kkc,
    output logic [2*KERNEL_W+CHANNEL_W-1:0]   col_blk_last,
    output logic [s2p_log2(S2P)-1:0]          col_lane_last,
    output logic [KNUM_W-1:0]                 kn_blk,
    output logic [s2p_log2(S2P)-1:0]          kn_lane_last,
    output logic [2*(TENSOR_W+1)-1:0]         pix,
    output logic [2*(TENSOR_W+1)-1:0]         pix_blk,
    output logic [s2p_log2(S2P)-1:0]          pix_rem,
    output logic [TENSOR_W+1+STRIDE_W-1:0]    row_step,
    output logic [ADDR_W-1:0]                 ska
);

    localparam int S2P_LOG2 = s2p_log2(S2P);
    localparam int TP_W     = TENSOR_W + 1;
    localparam int KKC_W    = 2*KERNEL_W + CHANNEL_W;
    localparam int PIX_W    = 2*TP_W;
    localparam int ROW_W    = TP_W + STRIDE_W;
    localparam int MA_W     = (2*KERNEL_W > TP_W) ? 2*KERNEL_W : TP_W;
    localparam int MB_W0    = (CHANNEL_W > TP_W) ? CHANNEL_W : TP_W;
    localparam int MB_W1    = (KERNEL_W > STRIDE_W) ? KERNEL_W : STRIDE_W;
    localparam int MB_W     = (MB_W0 > MB_W1) ? MB_W0 : MB_W1;
    localparam int SKA_W    = (PIX_W > ADDR_W) ? PIX_W : ADDR_W;

    conv_state_e state, state_nxt;

    logic [TP_W-1:0]       tp_in;
    logic [TP_W-1:0]       tp_q;
    logic [KERNEL_W-1:0]   k_q;
    logic [CHANNEL_W-1:0]  c_q;
    logic [STRIDE_W-1:0]   s_q;
    logic [KNUM_W-1:0]     n_q;
    logic [2*KERNEL_W-1:0] kk_q;

    logic                  accept;
    logic                  illegal;
    logic [TP_W-1:0]       diff;
    logic                  div_done;
    logic [TP_W-1:0]       div_quot_p1;
    logic [TP_W-1:0]       div_cycles;
    logic                  unused_div;

    logic [MA_W-1:0]       mul_a;
    logic [MB_W-1:0]       mul_b;
    logic [MA_W+MB_W-1:0]  mul_p;

    logic [KKC_W:0]        kkc_rnd;
    logic [KNUM_W:0]       n_rnd;
    logic [PIX_W:0]        pix_rnd;
    logic [SKA_W-1:0]      ska_full;

`ifdef CONV_PARAM_PAD_EN
    assign tp_in = TP_W'(tensor_size) + TP_W'({pad, 1'b0});
`else
    localparam int unused_pad_w = PAD_W;
    assign tp_in = TP_W'(tensor_size);
`endif

    assign accept  = cfg_valid && cfg_ready && !clear;
    assign diff    = tp_q - TP_W'(k_q);
    assign illegal = (s_q == '0) || (k_q == '0) || (TP_W'(k_q) > tp_q);

    conv_param_div #(
        .N_W (TP_W),
        .D_W (STRIDE_W)
    ) u_div (
        .clk      (clk),
        .rstn     (rstn),
        .start    (state == ST_LOAD),
        .en       (state == ST_DIV),
        .dividend (diff),
        .divisor  (s_q),
        .done     (div_done),
        .quot_p1  (div_quot_p1),
        .cycles   (div_cycles)
    );
    assign unused_div = ^div_cycles;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
        if (clear) begin
            state_nxt = ST_IDLE;
        end else if (cfg_valid && cfg_ready) begin
            state_nxt = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD: state_nxt = illegal ? ST_ERR : ST_DIV;
                ST_DIV:  if (div_done) state_nxt = ST_MUL0;
                ST_MUL0: state_nxt = ST_MUL1;
                ST_MUL1: state_nxt = ST_MUL2;
                ST_MUL2: state_nxt = ST_MUL3;
                ST_MUL3: state_nxt = ST_FIN;
                ST_FIN:  state_nxt = ST_DONE;
                default: ;
            endcase
        end
    end

    // One shared multiplier; the state selects which product is formed.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            ST_MUL0: begin mul_a = MA_W'(k_q);  mul_b = MB_W'(k_q); end
            ST_MUL1: begin mul_a = MA_W'(kk_q); mul_b = MB_W'(c_q); end
            ST_MUL2: begin mul_a = MA_W'(ofs);  mul_b = MB_W'(ofs); end
            ST_MUL3: begin mul_a = MA_W'(tp_q); mul_b = MB_W'(s_q); end
            default: ;
        endcase
    end
    assign mul_p = mul_a * mul_b;

    // Ceil-divides by S2P are add-(S2P-1)-then-shift; lane indices are masks.
    assign kkc_rnd  = {1'b0, kkc} + (KKC_W+1)'(S2P - 1);
    assign n_rnd    = {1'b0, n_q} + (KNUM_W+1)'(S2P - 1);
    assign pix_rnd  = {1'b0, pix} + (PIX_W+1)'(S2P - 1);
    assign ska_full = SKA_W'(pix) - SKA_W'(S2P - 1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tp_q          <= '0;
            k_q           <= '0;
            c_q           <= '0;
            s_q           <= '0;
            n_q           <= '0;
            kk_q          <= '0;
            param_valid   <= 1'b0;
            param_err     <= 1'b0;
            ofs           <= '0;
            kkc           <= '0;
            col_blk_last  <= '0;
            col_lane_last <= '0;
            kn_blk        <= '0;
            kn_lane_last  <= '0;
            pix           <= '0;
            pix_blk       <= '0;
            pix_rem       <= '0;
            row_step      <= '0;
            ska           <= '0;
        end else if (clear) begin
            param_valid <= 1'b0;
            param_err   <= 1'b0;
        end else if (accept) begin
            tp_q        <= tp_in;
            k_q         <= kernel_size;
            c_q         <= channels;
            s_q         <= stride;
            n_q         <= kernel_nums;
            param_valid <= 1'b0;
            param_err   <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: if (illegal) param_err <= 1'b1;
                ST_DIV:  if (div_done) ofs <= div_quot_p1;
                ST_MUL0: kk_q     <= mul_p[2*KERNEL_W-1:0];
                ST_MUL1: kkc      <= mul_p[KKC_W-1:0];
                ST_MUL2: pix      <= mul_p[PIX_W-1:0];
                ST_MUL3: row_step <= mul_p[ROW_W-1:0];
                ST_FIN: begin
                    col_blk_last  <= KKC_W'(kkc_rnd >> S2P_LOG2) - KKC_W'(1);
                    col_lane_last <= kkc[S2P_LOG2-1:0] - S2P_LOG2'(1);
                    kn_blk        <= KNUM_W'(n_rnd >> S2P_LOG2);
                    kn_lane_last  <= n_q[S2P_LOG2-1:0] - S2P_LOG2'(1);
                    pix_blk       <= PIX_W'(pix_rnd >> S2P_LOG2);
                    pix_rem       <= pix[S2P_LOG2-1:0];
                    ska           <= ska_full[ADDR_W-1:0];
                    param_valid   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_param_gen.sv
// Bench for conv_param_gen: directed cases plus random configs checked every
// cycle against an arithmetic model of the derived parameters and latency.
module tb_conv_param_gen;

    localparam int TW = 8, KW = 4, CW = 8, SW = 3, PW = 3, NW = 8, S2P = 8, AW = 16, LW = 3;
    localparam int KKC_W = 2*KW + CW;
    localparam int PIX_W = 2*(TW+1);

    logic clk = 1'b0, rstn = 1'b0, clear = 1'b0, cfg_valid = 1'b0;
    logic [TW-1:0] tensor_size = '0;
    logic [KW-1:0] kernel_size = '0;
    logic [CW-1:0] channels = '0;
    logic [SW-1:0] stride = '0;
`ifdef CONV_PARAM_PAD_EN
    logic [PW-1:0] pad = '0;
`endif
    logic [NW-1:0] kernel_nums = '0;

    logic              cfg_ready, param_valid, param_err;
    logic [TW:0]       ofs;
    logic [KKC_W-1:0]  kkc, col_blk_last;
    logic [LW-1:0]     col_lane_last, kn_lane_last, pix_rem;
    logic [NW-1:0]     kn_blk;
    logic [PIX_W-1:0]  pix, pix_blk;
    logic [TW+SW:0]    row_step;
    logic [AW-1:0]     ska;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    conv_param_gen #(
        .TENSOR_W(TW), .KERNEL_W(KW), .CHANNEL_W(CW), .STRIDE_W(SW),
        .PAD_W(PW), .KNUM_W(NW), .S2P(S2P), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rstn(rstn), .clear(clear), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .tensor_size(tensor_size), .kernel_size(kernel_size), .channels(channels), .stride(stride),
`ifdef CONV_PARAM_PAD_EN
        .pad(pad),
`endif
        .kernel_nums(kernel_nums), .param_valid(param_valid), .param_err(param_err),
        .ofs(ofs), .kkc(kkc), .col_blk_last(col_blk_last), .col_lane_last(col_lane_last),
        .kn_blk(kn_blk), .kn_lane_last(kn_lane_last), .pix(pix), .pix_blk(pix_blk),
        .pix_rem(pix_rem), .row_step(row_step), .ska(ska)
    );

    typedef struct {
        longint ofs, kkc, cbl, cll, knb, knl, pix, pixb, pixr, row, ska;
        int     lat;
        bit     ill;
    } exp_t;

    function automatic exp_t model(input longint t, k, c, s, p, n);
        exp_t   e;
        longint tp, q;
        e = '{default: 0};
        tp = (t + 2*p) % (longint'(1) << (TW+1));
        e.ill = (s == 0) || (k == 0) || (k > tp);
        e.lat = 1;
        if (e.ill) return e;
        q      = (tp - k) / s;
        e.ofs  = q + 1;
        e.kkc  = k * k * c;
        e.cbl  = ((e.kkc + S2P - 1) / S2P - 1) & ((longint'(1) << KKC_W) - 1);
        e.cll  = (e.kkc + S2P - 1) % S2P;
        e.knb  = (n + S2P - 1) / S2P;
        e.knl  = (n + S2P - 1) % S2P;
        e.pix  = e.ofs * e.ofs;
        e.pixb = (e.pix + S2P - 1) / S2P;
        e.pixr = e.pix % S2P;
        e.row  = tp * s;
        e.ska  = (e.pix - S2P + 1) & ((longint'(1) << AW) - 1);
        e.lat  = int'(q) + 7;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour: handshake, completion after the computed latency, clear and reset.
    exp_t m_exp;
    logic m_ready, m_valid, m_err;
    int   m_left;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_ready <= 1'b1; m_valid <= 1'b0; m_err <= 1'b0; m_left <= 0;
        end else if (clear) begin
            m_ready <= 1'b1; m_valid <= 1'b0; m_err <= 1'b0; m_left <= 0;
        end else if (cfg_valid && m_ready) begin
`ifdef CONV_PARAM_PAD_EN
            m_exp <= model(tensor_size, kernel_size, channels, stride, pad, kernel_nums);
            m_left <= model(tensor_size, kernel_size, channels, stride, pad, kernel_nums).lat;
`else
            m_exp <= model(tensor_size, kernel_size, channels, stride, 0, kernel_nums);
            m_left <= model(tensor_size, kernel_size, channels, stride, 0, kernel_nums).lat;
`endif
            m_ready <= 1'b0; m_valid <= 1'b0; m_err <= 1'b0;
        end else if (m_left > 0) begin
            if (m_left == 1) begin
                m_ready <= 1'b1;
                if (m_exp.ill) m_err <= 1'b1;
                else           m_valid <= 1'b1;
            end
            m_left <= m_left - 1;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("cfg_ready", cfg_ready, m_ready);
            chk("param_valid", param_valid, m_valid);
            chk("param_err", param_err, m_err);
            if (m_valid) begin
                chk("ofs", ofs, m_exp.ofs);
                chk("kkc", kkc, m_exp.kkc);
                chk("col_blk_last", col_blk_last, m_exp.cbl);
                chk("col_lane_last", col_lane_last, m_exp.cll);
                chk("kn_blk", kn_blk, m_exp.knb);
                chk("kn_lane_last", kn_lane_last, m_exp.knl);
                chk("pix", pix, m_exp.pix);
                chk("pix_blk", pix_blk, m_exp.pixb);
                chk("pix_rem", pix_rem, m_exp.pixr);
                chk("row_step", row_step, m_exp.row);
                chk("ska", ska, m_exp.ska);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
        chk({tag, "_param_valid"}, param_valid, 0);
        chk({tag, "_param_err"}, param_err, 0);
        chk({tag, "_ofs"}, ofs, 0);
        chk({tag, "_kkc"}, kkc, 0);
        chk({tag, "_col_blk_last"}, col_blk_last, 0);
        chk({tag, "_col_lane_last"}, col_lane_last, 0);
        chk({tag, "_kn_blk"}, kn_blk, 0);
        chk({tag, "_kn_lane_last"}, kn_lane_last, 0);
        chk({tag, "_pix"}, pix, 0);
        chk({tag, "_pix_blk"}, pix_blk, 0);
        chk({tag, "_pix_rem"}, pix_rem, 0);
        chk({tag, "_row_step"}, row_step, 0);
        chk({tag, "_ska"}, ska, 0);
    endtask

    task automatic apply(input int t, k, c, s, p, n);
        @(negedge clk);
        tensor_size = TW'(t);
        kernel_size = KW'(k);
        channels    = CW'(c);
        stride      = SW'(s);
`ifdef CONV_PARAM_PAD_EN
        pad         = PW'(p);
`else
        if (p != 0) $display("note: pad %0d ignored in this build", p);
`endif
        kernel_nums = NW'(n);
        cfg_valid   = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid   = 1'b0;
        tensor_size = TW'($urandom);
        kernel_size = KW'($urandom);
        channels    = CW'($urandom);
        stride      = SW'($urandom);
        kernel_nums = NW'($urandom);
        chk("accept_valid_low", param_valid, 0);
        chk("accept_err_low", param_err, 0);
        chk("accept_busy", cfg_ready, 0);
    endtask

    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (param_valid || param_err) begin
                n = i;
                break;
            end
        end
        if (n < 0) begin
            n_chk++;
            n_err++;
            $display("FAIL done_timeout: no param_valid/param_err within %0d cycles", budget);
        end
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rstn = 1'b1;
        @(negedge clk);

        // T=8 K=3 C=16 S=1 N=20
        apply(8, 3, 16, 1, 0, 20);
        wait_done(600, n);
        chk("t1_latency", n, 12);
        chk("t1_ofs", ofs, 6);
        chk("t1_kkc", kkc, 144);
        chk("t1_col_blk_last", col_blk_last, 17);
        chk("t1_col_lane_last", col_lane_last, 7);
        chk("t1_kn_blk", kn_blk, 3);
        chk("t1_kn_lane_last", kn_lane_last, 3);
        chk("t1_pix", pix, 36);
        chk("t1_pix_blk", pix_blk, 5);
        chk("t1_pix_rem", pix_rem, 4);
        chk("t1_row_step", row_step, 8);
        chk("t1_ska", ska, 29);

        // Reconfigure from DONE; Tp=9, S=2, C=3, N=8
`ifdef CONV_PARAM_PAD_EN
        apply(7, 3, 3, 2, 1, 8);
`else
        apply(9, 3, 3, 2, 0, 8);
`endif
        wait_done(600, n);
        chk("t2_latency", n, 10);
        chk("t2_ofs", ofs, 4);
        chk("t2_kkc", kkc, 27);
        chk("t2_col_blk_last", col_blk_last, 3);
        chk("t2_col_lane_last", col_lane_last, 2);
        chk("t2_kn_blk", kn_blk, 1);
        chk("t2_kn_lane_last", kn_lane_last, 7);
        chk("t2_pix", pix, 16);
        chk("t2_pix_blk", pix_blk, 2);
        chk("t2_pix_rem", pix_rem, 0);
        chk("t2_row_step", row_step, 18);

        // Illegal: K > Tp, then S == 0 (accepted from ERR)
        apply(8, 9, 4, 1, 0, 5);
        wait_done(600, n);
        chk("bigk_latency", n, 1);
        chk("bigk_err", param_err, 1);
        chk("bigk_valid", param_valid, 0);
        apply(8, 3, 4, 0, 0, 5);
        wait_done(600, n);
        chk("s0_latency", n, 1);
        chk("s0_err", param_err, 1);
        chk("s0_valid", param_valid, 0);

        // N == 0 edge case
        apply(8, 3, 16, 1, 0, 0);
        wait_done(600, n);
        chk("n0_kn_blk", kn_blk, 0);
        chk("n0_kn_lane_last", kn_lane_last, S2P - 1);

        // Clear during DIV, then a legal config
        apply(8, 3, 16, 1, 0, 20);
        repeat (3) @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clr_ready", cfg_ready, 1);
        chk("clr_valid", param_valid, 0);
        chk("clr_err", param_err, 0);
        apply(20, 5, 7, 3, 0, 33);
        wait_done(600, n);
        chk("after_clr_latency", n, 12);

        // Reset asserted while in MUL2 (q=5 -> MUL2 after E0+9)
        apply(8, 3, 16, 1, 0, 20);
        repeat (9) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", cfg_ready, 1);

        for (int it = 0; it < 40; it++) begin
            int t, k, c, s, p, nk;
            t  = $urandom_range(0, 255);
            k  = $urandom_range(0, 15);
            c  = $urandom_range(0, 255);
            s  = $urandom_range(0, 7);
            nk = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
`ifdef CONV_PARAM_PAD_EN
            p  = $urandom_range(0, 7);
`else
            p  = 0;
`endif
            apply(t, k, c, s, p, nk);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 5)) @(posedge clk);
                @(negedge clk);
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
            end else begin
                wait_done(600, n);
                chk("rand_latency", n, m_exp.lat);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_param_gen.md
# conv_param_gen

Parametrised convolution-parameter generator for the IMG2COL/GEMM datapath. It accepts one layer configuration over a valid/ready handshake, validates it, and sequentially derives every count the address generators, matrix adder and result processor need. Derived values include output size with padding, K·K·C, block counts and last-lane indices per S2P lane group. It sits between the host/config registers and the tensor-address, weight-address, matrix-add and result-process blocks, and holds its results stable with a valid flag until cleared or reconfigured.

## Interface
Parameters:
- TENSOR_W, 8: input tensor edge width.
- KERNEL_W, 4: kernel edge width.
- CHANNEL_W, 8: channel count width.
- STRIDE_W, 3: stride width.
- PAD_W, 3: padding width.
- KNUM_W, 8: kernel count width.
- S2P, 8: lanes per block; power of two, at least 2.
- ADDR_W, 16: address result width.

Ports:
- clk  in  1  clock; single clock domain.
- rstn  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; returns the block to IDLE.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  high in IDLE, DONE and ERR.
- tensor_size  in  TENSOR_W  T.
- kernel_size  in  KERNEL_W  K.
- channels  in  CHANNEL_W  C.
- stride  in  STRIDE_W  S.
- pad  in  PAD_W  P; present only with CONV_PARAM_PAD_EN.
- kernel_nums  in  KNUM_W  N.
- param_valid  out  1  all results valid and stable.
- param_err  out  1  last accepted configuration was illegal.
- ofs  out  TENSOR_W+1  output edge O.
- kkc  out  2·KERNEL_W+CHANNEL_W  K·K·C.
- col_blk_last  out  2·KERNEL_W+CHANNEL_W  ceil(kkc/S2P)−1.
- col_lane_last  out  log2(S2P)  (kkc−1) mod S2P.
- kn_blk  out  KNUM_W  ceil(N/S2P).
- kn_lane_last  out  log2(S2P)  (N−1) mod S2P.
- pix  out  2·(TENSOR_W+1)  O·O.
- pix_blk  out  2·(TENSOR_W+1)  ceil(pix/S2P).
- pix_rem  out  log2(S2P)  pix mod S2P.
- row_step  out  TENSOR_W+1+STRIDE_W  Tp·S.
- ska  out  ADDR_W  pix−S2P+1, truncated.

## Operation
- Tp = T+2P and diff = Tp−K are computed at TENSOR_W+1 bits. With the macro off, P is 0.
- States: IDLE → LOAD → DIV → MUL0..MUL3 → FIN → DONE. LOAD can instead go to ERR.
- Handshake: a configuration is accepted on any edge where cfg_valid && cfg_ready. Inputs are captured at that edge and later input changes are ignored.
- Acceptance clears param_valid and param_err at that same edge and enters LOAD. Acceptance is allowed from DONE and from ERR.
- LOAD:
  - If S==0, K==0 or K>Tp, go to ERR. Otherwise go to DIV.
  - Clears the DIV accumulator and count.
- DIV: iterative subtraction.
  - If acc+S > diff, set O = count+1 and go to MUL0.
  - Otherwise acc += S and count++.
  - Takes q+1 cycles, where q = floor(diff/S).
- MUL0..MUL3 use one shared multiplier, one product per state, in this order:
  - MUL0: K·K.
  - MUL1: KK·C.
  - MUL2: O·O.
  - MUL3: Tp·S.
- FIN: computes block counts, lane indices and ska with shifts and masks only; there are no dividers. It then sets param_valid.
- DONE and ERR hold all outputs until a new acceptance, clear or reset.
- clear has priority over cfg_valid. It works in any state, mid-computation included: it forces IDLE, and clears param_valid and param_err.
- Result registers keep their stale values after clear but are qualified by param_valid. Only reset zeroes them.
- Edge case: N==0 gives kn_blk=0 and kn_lane_last=S2P−1.

## Timing
- Reset values: every output is 0, except cfg_ready, which is 1 (IDLE).
- Latency: with acceptance at edge E0, param_valid rises at E0+q+7.
- Illegal configuration: param_err rises at E0+1; param_valid stays 0.
- cfg_ready is 0 from E0+1 until DONE or ERR is entered, and is 1 in the cycle after that entry edge.
- A reset assertion mid-DIV or mid-MUL takes effect immediately (asynchronous) and returns the block to reset values.

## Configuration
- CONV_PARAM_PAD_EN:
  - Defined: the pad port exists and Tp = T+2P.
  - Undefined: the port is absent, P is 0, and the padding adder logic is removed. Results equal the defined build with P=0.

## Structure
- conv_param_pkg holds:
  - the state enum;
  - the S2P_LOG2 localparam function;
  - a packed result struct carrying all output fields, used by downstream consumers.
- Sub-module conv_param_div: the start/done iterative subtract divider used by DIV. It returns the quotient+1 and the cycle count. The shared multiplier stays in the top level.

## Test plan
- T=8, K=3, C=16, S=1, P=0, N=20, S2P=8. Expected:
  - O=6, kkc=144, col_blk_last=17, col_lane_last=7;
  - kn_blk=3, kn_lane_last=3;
  - pix=36, pix_blk=5, pix_rem=4;
  - row_step=8;
  - param_valid at E0+12.
- With the macro on: T=7, K=3, S=2, P=1, C=3, N=8. Expected:
  - Tp=9, O=4, kkc=27, col_blk_last=3, col_lane_last=2;
  - kn_blk=1, kn_lane_last=7;
  - pix=16, pix_blk=2, pix_rem=0;
  - row_step=18;
  - param_valid at E0+10.
- Illegal configurations:
  - K=9 with T=8, P=0 → param_err=1 at E0+1, param_valid stays 0.
  - S=0 → same response.
- clear during DIV → IDLE next cycle, cfg_ready=1, param_valid=0. A following legal configuration gives correct results.
- New configuration accepted while in DONE → param_valid drops on the acceptance edge, then rises with the new values at the new latency.
- Reset asserted mid-MUL2 → all outputs return to 0 immediately and cfg_ready=1 after reset is released.
